// File: rtl/load_align_unit_pkg.sv
//==============================================================================
// Module : load_align_unit_pkg
// Brief  : Opcodes, FSM state type and load-opcode decode for load_align_unit.
//          LWL/LWR decode as loads only when LOAD_ALIGN_LWLR_EN is defined.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package load_align_unit_pkg;

    localparam logic [5:0] OPCODE_LB  = 6'h20;
    localparam logic [5:0] OPCODE_LH  = 6'h21;
    localparam logic [5:0] OPCODE_LWL = 6'h22;
    localparam logic [5:0] OPCODE_LW  = 6'h23;
    localparam logic [5:0] OPCODE_LBU = 6'h24;
    localparam logic [5:0] OPCODE_LHU = 6'h25;
    localparam logic [5:0] OPCODE_LWR = 6'h26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } load_align_state_t;

    function automatic logic is_load_opcode(input logic [5:0] op);
        case (op)
            OPCODE_LB, OPCODE_LBU, OPCODE_LH, OPCODE_LHU, OPCODE_LW: return 1'b1;
`ifdef LOAD_ALIGN_LWLR_EN
            OPCODE_LWL, OPCODE_LWR:                                 return 1'b1;
`endif
            default:                                                return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_align_unit_if.sv
//==============================================================================
// Module : load_align_unit_if
// Brief  : Request, data-bus and response signals of the load align unit.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface load_align_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic [5:0]              req_opcode;
    logic [31:0]             req_addr;
    logic [31:0]             req_rt_old;
    logic [31:0]             mem_address;
    logic                    mem_read;
    logic [DATA_WIDTH/8-1:0] mem_byteenable;
    logic                    mem_waitrequest;
    logic [DATA_WIDTH-1:0]   mem_readdata;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [31:0]             resp_data;
    logic                    resp_error;

    // slave: the load unit itself
    modport slave (
        input  req_valid, req_opcode, req_addr, req_rt_old,
        output req_ready,
        output mem_address, mem_read, mem_byteenable,
        input  mem_waitrequest, mem_readdata,
        output resp_valid, resp_data, resp_error,
        input  resp_ready
    );

    modport master (
        output req_valid, req_opcode, req_addr, req_rt_old,
        input  req_ready,
        input  mem_address, mem_read, mem_byteenable,
        output mem_waitrequest, mem_readdata,
        input  resp_valid, resp_data, resp_error,
        output resp_ready
    );
endinterface

`default_nettype wire

// File: rtl/load_align_unit_extract.sv
//==============================================================================
// Module : load_extract
// Brief  : Combinational word select, lane shift, sign/zero extend and
//          LWL/LWR merge (merge present when LOAD_ALIGN_LWLR_EN is defined).
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module load_extract
    import load_align_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_W     = 2
) (
    input  logic [5:0]            opcode,
    input  logic [LANE_W-1:0]     lane,
    input  logic [31:0]           rt_old,
    input  logic [DATA_WIDTH-1:0] readdata,
    output logic [31:0]           data
);
    logic [31:0] w_word;
    logic [31:0] w_shifted;
    logic [1:0]  w_b;
    logic [4:0]  w_rsh;
    logic [4:0]  w_lsh;

    assign w_b   = lane[1:0];
    assign w_rsh = {w_b, 3'b000};
    // 8*(3-b) == 8*~b for a two-bit b
    assign w_lsh = {~w_b, 3'b000};

    generate
        if (DATA_WIDTH == 64) begin : g_word64
            assign w_word = lane[LANE_W-1] ? readdata[63:32] : readdata[31:0];
        end else begin : g_word32
            assign w_word = readdata[31:0];
        end
    endgenerate

    assign w_shifted = w_word >> w_rsh;

    always_comb begin
        data = '0;
        case (opcode)
            OPCODE_LB:  data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            OPCODE_LBU: data = {24'h0, w_shifted[7:0]};
            OPCODE_LH:  data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            OPCODE_LHU: data = {16'h0, w_shifted[15:0]};
            OPCODE_LW:  data = w_word;
`ifdef LOAD_ALIGN_LWLR_EN
            OPCODE_LWL: data = (w_word << w_lsh) | (rt_old & ~(32'hFFFF_FFFF << w_lsh));
            OPCODE_LWR: data = w_shifted | (rt_old & ~(32'hFFFF_FFFF >> w_rsh));
`endif
            default:    data = '0;
        endcase
    end

`ifndef LOAD_ALIGN_LWLR_EN
    logic w_unused_rt;
    assign w_unused_rt = ^rt_old;
`endif

endmodule

`default_nettype wire

// File: rtl/load_align_unit.sv
//==============================================================================
// Module : load_align_unit
// Brief  : Owns one data-memory read for LB/LBU/LH/LHU/LW (LWL/LWR when
//          LOAD_ALIGN_LWLR_EN is defined) and returns the aligned 32-bit value.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    load_align_unit_if.slave  bus
);
    localparam int C_BW    = DATA_WIDTH / 8;
    localparam int C_OFS   = $clog2(C_BW);
    localparam int C_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_TO_LAST =
        C_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    load_align_state_t   r_state;
    logic [5:0]          r_opcode;
    logic [C_OFS-1:0]    r_lane;
    logic [31:0]         r_rt_old;
    logic [31:0]         r_mem_address;
    logic                r_mem_read;
    logic [C_BW-1:0]     r_be;
    logic                r_resp_valid;
    logic [31:0]         r_resp_data;
    logic                r_resp_error;
    logic [C_CNT_W-1:0]  r_cnt;

    logic [1:0]          w_b;
    logic [3:0]          w_be_word;
    logic [C_BW-1:0]     w_be;
    logic                w_misaligned;
    logic                w_req_ok;
    logic                w_timeout;
    logic [31:0]         w_load_data;

    assign w_b = bus.req_addr[1:0];

    always_comb begin
        w_be_word    = 4'b0000;
        w_misaligned = 1'b0;
        case (bus.req_opcode)
            OPCODE_LB, OPCODE_LBU: w_be_word = 4'b0001 << w_b;
            OPCODE_LH, OPCODE_LHU: begin
                w_be_word    = 4'b0011 << w_b;
                w_misaligned = w_b[0];
            end
            OPCODE_LW: begin
                w_be_word    = 4'b1111;
                w_misaligned = |w_b;
            end
`ifdef LOAD_ALIGN_LWLR_EN
            OPCODE_LWL: w_be_word = 4'b1111 >> ~w_b;
            OPCODE_LWR: w_be_word = 4'b1111 << w_b;
`endif
            default: w_be_word = 4'b0000;
        endcase
    end

    generate
        if (DATA_WIDTH == 64) begin : g_be64
            assign w_be = bus.req_addr[2] ? {w_be_word, 4'b0000} : {4'b0000, w_be_word};
        end else begin : g_be32
            assign w_be = w_be_word;
        end
    endgenerate

    assign w_req_ok  = is_load_opcode(bus.req_opcode) && !w_misaligned;
    assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_cnt == C_TO_LAST);

    load_extract #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_W     (C_OFS)
    ) u_extract (
        .opcode   (r_opcode),
        .lane     (r_lane),
        .rt_old   (r_rt_old),
        .readdata (bus.mem_readdata),
        .data     (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_opcode      <= '0;
            r_lane        <= '0;
            r_rt_old      <= '0;
            r_mem_address <= '0;
            r_mem_read    <= 1'b0;
            r_be          <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_data   <= '0;
            r_resp_error  <= 1'b0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_opcode <= bus.req_opcode;
                        r_lane   <= bus.req_addr[C_OFS-1:0];
                        r_rt_old <= bus.req_rt_old;
                        if (w_req_ok) begin
                            r_state       <= READ;
                            r_mem_read    <= 1'b1;
                            r_mem_address <= {bus.req_addr[31:C_OFS], {C_OFS{1'b0}}};
                            r_be          <= w_be;
                            r_cnt         <= '0;
                        end else begin
                            // rejected requests never touch the bus
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                            r_resp_data  <= '0;
                        end
                    end
                end
                READ: begin
                    if (!bus.mem_waitrequest) begin
                        r_state      <= RESP;
                        r_mem_read   <= 1'b0;
                        r_be         <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_error <= 1'b0;
                        r_resp_data  <= w_load_data;
                    end else if (w_timeout) begin
                        r_state      <= RESP;
                        r_mem_read   <= 1'b0;
                        r_be         <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_error <= 1'b1;
                        r_resp_data  <= '0;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_error <= 1'b0;
                        r_resp_data  <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready      = (r_state == IDLE);
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_read       = r_mem_read;
    assign bus.mem_byteenable = r_be;
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_data      = r_resp_data;
    assign bus.resp_error     = r_resp_error;

endmodule

`default_nettype wire

// File: tb/tb_load_align_unit.sv
//==============================================================================
// Module : tb_load_align_unit
// Brief  : Scoreboard bench for load_align_unit (64-bit bus, timeout 6);
//          LWL/LWR cases follow LOAD_ALIGN_LWLR_EN.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_load_align_unit;
    import load_align_unit_pkg::*;

    localparam int DW = 64;
    localparam int TO = 6;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  be;
        logic [63:0] rdata;
        int          stalls;
    } mem_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    exp_t exp_q[$];
    mem_t mem_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    load_align_unit_if #(.DATA_WIDTH(DW)) bus ();

    load_align_unit #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: load semantics from the ISA rules, byte-lane arithmetic on a 64-bit beat
    function automatic void model(input logic [5:0] op, input logic [31:0] a,
                                  input logic [31:0] rt, input logic [63:0] rd,
                                  output logic err, output logic [31:0] res,
                                  output logic [7:0] be);
        int          b  = int'(a[1:0]);
        int          wo = a[2] ? 4 : 0;
        logic [31:0] w  = a[2] ? rd[63:32] : rd[31:0];
        int unsigned f;
        int          sh;
        err = 1'b0;
        res = '0;
        be  = '0;
        case (op)
            OPCODE_LB, OPCODE_LBU: begin
                f   = (w >> (8 * b)) & 32'hFF;
                res = (op == OPCODE_LB && f >= 128) ? f - 256 : f;
                be  = 8'(1 << (wo + b));
            end
            OPCODE_LH, OPCODE_LHU: begin
                err = a[0];
                f   = (w >> (8 * b)) & 32'hFFFF;
                res = (op == OPCODE_LH && f >= 32768) ? f - 65536 : f;
                be  = 8'(3 << (wo + b));
            end
            OPCODE_LW: begin
                err = (a[1:0] != 2'b00);
                res = w;
                be  = 8'(15 << wo);
            end
`ifdef LOAD_ALIGN_LWLR_EN
            OPCODE_LWL: begin
                sh  = 8 * (3 - b);
                res = (w << sh) | (rt & 32'((64'd1 << sh) - 1));
                be  = 8'(((1 << (b + 1)) - 1) << wo);
            end
            OPCODE_LWR: begin
                res = (w >> (8 * b)) | (rt & ~(32'hFFFF_FFFF >> (8 * b)));
                be  = 8'(((15 << b) & 15) << wo);
            end
`endif
            default: err = 1'b1;
        endcase
        if (err) begin
            res = '0;
            be  = '0;
        end
    endfunction

    // Memory responder: checks each bus request and plays back its stall count
    bit   m_active = 1'b0;
    int   m_left   = 0;
    int   m_cycles = 0;
    mem_t m_cur;

    initial begin
        bus.mem_waitrequest = 1'b1;
        bus.mem_readdata    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_active            = 1'b0;
                bus.mem_waitrequest = 1'b1;
            end else if (bus.mem_read) begin
                if (!m_active) begin
                    check("read_expected", 64'(mem_q.size() != 0), 64'd1);
                    if (mem_q.size() != 0) m_cur = mem_q.pop_front();
                    else m_cur = '{32'h0, 8'h0, 64'h0, 1 << 20};
                    check("mem_address", 64'(bus.mem_address), 64'(m_cur.addr));
                    check("mem_byteenable", 64'(bus.mem_byteenable), 64'(m_cur.be));
                    m_left   = m_cur.stalls;
                    m_cycles = 0;
                    m_active = 1'b1;
                end else begin
                    check("mem_req_stable", {24'h0, bus.mem_byteenable, bus.mem_address},
                          {24'h0, m_cur.be, m_cur.addr});
                end
                m_cycles++;
                if (m_left > 0) begin
                    bus.mem_waitrequest = 1'b1;
                    bus.mem_readdata    = {$urandom, $urandom};
                    m_left--;
                end else begin
                    bus.mem_waitrequest = 1'b0;
                    bus.mem_readdata    = m_cur.rdata;
                end
            end else begin
                if (m_active)
                    check("read_cycles", 64'(m_cycles),
                          64'((m_cur.stalls >= TO) ? TO : m_cur.stalls + 1));
                m_active            = 1'b0;
                bus.mem_waitrequest = 1'($urandom_range(0, 1));
                bus.mem_readdata    = {$urandom, $urandom};
            end
        end
    end

    // Response monitor: pops the scoreboard on each new response, randomly stalls resp_ready
    bit   r_in = 1'b0;
    bit   have = 1'b0;
    int   hold = 0;
    exp_t cur;

    initial begin
        bus.resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                r_in           = 1'b0;
                bus.resp_ready = 1'b0;
            end else if (bus.resp_valid) begin
                if (!r_in) begin
                    check("resp_expected", 64'(exp_q.size() != 0), 64'd1);
                    have = (exp_q.size() != 0);
                    if (have) begin
                        cur = exp_q.pop_front();
                        check("resp_latency", 64'(cyc - cur.acc), 64'(cur.lat));
                    end
                    hold = $urandom_range(0, 3);
                    r_in = 1'b1;
                end
                if (have) begin
                    check("resp_data", 64'(bus.resp_data), 64'(cur.data));
                    check("resp_error", 64'(bus.resp_error), 64'(cur.err));
                end
                bus.resp_ready = (hold == 0);
                if (hold > 0) hold--;
            end else begin
                r_in           = 1'b0;
                bus.resp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic do_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                          input logic [63:0] rd, input int stalls);
        logic        err;
        logic [31:0] res;
        logic [7:0]  be;
        exp_t        e;
        bit          acc = 1'b0;
        model(op, a, rt, rd, err, res, be);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_opcode = op;
        bus.req_addr   = a;
        bus.req_rt_old = rt;
        for (int i = 0; i < 60 && !acc; i++) begin
            @(posedge clk);
            acc = bus.req_ready;
        end
        check("req_accepted", 64'(acc), 64'd1);
        #1;
        if (acc) begin
            e.acc = cyc;
            if (err) begin
                e.err = 1'b1; e.data = '0; e.lat = 0;
            end else begin
                mem_q.push_back('{{a[31:3], 3'b000}, be, rd, stalls});
                if (stalls >= TO) begin
                    e.err = 1'b1; e.data = '0; e.lat = TO;
                end else begin
                    e.err = 1'b0; e.data = res; e.lat = stalls + 1;
                end
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_opcode = 6'($urandom);
        bus.req_addr   = $urandom;
        bus.req_rt_old = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.resp_valid); i++) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    logic [5:0] ops[10];
    bit         acc2;

    initial begin
        ops = '{OPCODE_LB, OPCODE_LBU, OPCODE_LH, OPCODE_LHU, OPCODE_LW,
                OPCODE_LWL, OPCODE_LWR, 6'h00, 6'h2B, 6'h0F};
        bus.req_valid  = 1'b0;
        bus.req_opcode = '0;
        bus.req_addr   = '0;
        bus.req_rt_old = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_mem_read", 64'(bus.mem_read), 64'd0);
        check("rst_byteenable", 64'(bus.mem_byteenable), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_data", 64'(bus.resp_data), 64'd0);
        check("rst_resp_error", 64'(bus.resp_error), 64'd0);
        reset = 1'b0;

        do_txn(OPCODE_LB,  32'h103, 32'h0, 64'h0000_0000_8011_2233, 0);
        do_txn(OPCODE_LHU, 32'h102, 32'h0, 64'h0000_0000_BEEF_1234, 3);
        do_txn(OPCODE_LH,  32'h101, 32'h0, 64'h0, 0);
        do_txn(OPCODE_LW,  32'h104, 32'h0, 64'hCAFE_F00D_1234_5678, 0);
        do_txn(OPCODE_LWL, 32'h101, 32'h1122_3344, 64'h0000_0000_AABB_CCDD, 0);
        do_txn(OPCODE_LWR, 32'h101, 32'h1122_3344, 64'h0000_0000_AABB_CCDD, 1);
        do_txn(OPCODE_LW,  32'h108, 32'h0, 64'h1, TO - 1);
        do_txn(OPCODE_LW,  32'h10C, 32'h0, 64'h1, TO);
        do_txn(OPCODE_LB,  32'h107, 32'h0, 64'h7F00_0000_0000_0000, TO + 4);

        for (int n = 0; n < 150; n++) begin
            int r = $urandom_range(0, 9);
            int st = (r < 6) ? $urandom_range(0, 3) : (r == 6) ? TO - 1 : (r == 7) ? TO : TO + 3;
            do_txn(ops[$urandom_range(0, 9)], $urandom, $urandom, {$urandom, $urandom}, st);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        // Abandon a stalled read with reset
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_opcode = OPCODE_LW;
        bus.req_addr   = 32'h200;
        mem_q.push_back('{32'h200, 8'h0F, 64'h0, 1 << 20});
        acc2 = 1'b0;
        for (int i = 0; i < 20 && !acc2; i++) begin
            @(posedge clk);
            acc2 = bus.req_ready;
        end
        check("reset_txn_accepted", 64'(acc2), 64'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mem_read_before_reset", 64'(bus.mem_read), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mem_read", 64'(bus.mem_read), 64'd0);
        check("reset_req_ready", 64'(bus.req_ready), 64'd1);
        check("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        do_txn(OPCODE_LBU, 32'h305, 32'h0, 64'h0000_9A00_0000_0000, 2);
        drain();
        check("mem_q_empty", 64'(mem_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
